// File: rtl/poly_modsub_seq_if.sv
// rtl/poly_modsub_seq_if.sv - handshake and coefficient-memory bus of poly_modsub_seq
//
// Groups every non-clock/reset signal of the sequencer.
//   slave  : the sequencer side (takes start/config/read data, drives reads/writes/status)
//   master : the controlling FSM + memory side
// Optional feature macro: POLY_MODSUB_ADD_EN adds op_i (0 = subtract, 1 = add).
interface poly_modsub_seq_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  start_i;
  logic [DATA_WIDTH-1:0] modulus_i;
  logic [ADDR_WIDTH-1:0] base_a_i;
  logic [ADDR_WIDTH-1:0] base_b_i;
  logic [ADDR_WIDTH-1:0] base_c_i;
`ifdef POLY_MODSUB_ADD_EN
  logic                  op_i;
`endif
  logic                  rd_en_o;
  logic [ADDR_WIDTH-1:0] rd_addr_a_o;
  logic [ADDR_WIDTH-1:0] rd_addr_b_o;
  logic [DATA_WIDTH-1:0] rd_data_a_i;
  logic [DATA_WIDTH-1:0] rd_data_b_i;
  logic                  wr_en_o;
  logic [ADDR_WIDTH-1:0] wr_addr_o;
  logic [DATA_WIDTH-1:0] wr_data_o;
  logic                  busy_o;
  logic                  done_o;

  modport slave (
`ifdef POLY_MODSUB_ADD_EN
    input  op_i,
`endif
    input  start_i, modulus_i, base_a_i, base_b_i, base_c_i,
    input  rd_data_a_i, rd_data_b_i,
    output rd_en_o, rd_addr_a_o, rd_addr_b_o,
    output wr_en_o, wr_addr_o, wr_data_o,
    output busy_o, done_o
  );

  modport master (
`ifdef POLY_MODSUB_ADD_EN
    output op_i,
`endif
    output start_i, modulus_i, base_a_i, base_b_i, base_c_i,
    output rd_data_a_i, rd_data_b_i,
    input  rd_en_o, rd_addr_a_o, rd_addr_b_o,
    input  wr_en_o, wr_addr_o, wr_data_o,
    input  busy_o, done_o
  );
endinterface

// File: rtl/poly_modsub_seq.sv
// rtl/poly_modsub_seq.sv - streams c[i] = (a[i] - b[i]) mod q over a whole polynomial
//
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : poly_modsub_seq_if.slave (start/config, paired reads from banks A/B,
//           destination writes, busy/done status)
// Pipeline: read issue -> (1 cycle memory) compute+register -> write, 1 coeff/cycle.
// Optional feature macro: POLY_MODSUB_ADD_EN (op_i selects modular add when 1).
module poly_modsub_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int N_COEFFS   = 256
) (
  input  logic             clk_i,
  input  logic             rst_i,
  poly_modsub_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_DRAIN  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N_COEFFS - 1);

  state_t                state, state_nx;
  logic                  start_ok;

  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] idx_d;
  logic [DATA_WIDTH-1:0] q;
  logic [ADDR_WIDTH-1:0] base_a, base_b, base_c;
  logic                  valid_d;
`ifdef POLY_MODSUB_ADD_EN
  logic                  op_add;
`endif

  logic                  rd_en, busy, done;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  logic [DATA_WIDTH:0]   qx, ax, bx, t;
  logic [DATA_WIDTH-1:0] r;

  assign start_ok = (state == S_IDLE) && bus.start_i;

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (bus.start_i) state_nx = S_RUN;
      S_RUN:    if (idx == LAST_IDX) state_nx = S_DRAIN;
      // first DRAIN cycle still has the last read's data in flight; once the
      // delay flag drops, the final write is on the bus this cycle
      S_DRAIN:  if (!valid_d) state_nx = S_FINISH;
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    rd_en = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      S_RUN:    begin rd_en = 1'b1; busy = 1'b1; end
      S_DRAIN:  busy = 1'b1;
      S_FINISH: done = 1'b1;
      default:  ;
    endcase
  end

  // Modular arithmetic on DATA_WIDTH+1 bits so a + q - b never overflows.
  assign qx = {1'b0, q};
  assign ax = {1'b0, bus.rd_data_a_i};
  assign bx = {1'b0, bus.rd_data_b_i};
`ifdef POLY_MODSUB_ADD_EN
  assign t  = op_add ? (ax + bx) : (ax + qx - bx);
`else
  assign t  = ax + qx - bx;
`endif
  assign r  = (t >= qx) ? DATA_WIDTH'(t - qx) : DATA_WIDTH'(t);

  // datapath and configuration registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx     <= '0;
      idx_d   <= '0;
      q       <= '0;
      base_a  <= '0;
      base_b  <= '0;
      base_c  <= '0;
      valid_d <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
`ifdef POLY_MODSUB_ADD_EN
      op_add  <= 1'b0;
`endif
    end else begin
      valid_d <= rd_en;
      wr_en   <= valid_d;
      if (start_ok) begin
        q      <= bus.modulus_i;
        base_a <= bus.base_a_i;
        base_b <= bus.base_b_i;
        base_c <= bus.base_c_i;
        idx    <= '0;
`ifdef POLY_MODSUB_ADD_EN
        op_add <= bus.op_i;
`endif
      end else if (state == S_RUN) begin
        idx <= idx + 1'b1;
      end
      // index travels alongside the read so the write address lines up with its data
      if (rd_en) idx_d <= idx;
      // write address/data hold their last value between writes
      if (valid_d) begin
        wr_data <= r;
        wr_addr <= base_c + idx_d;
      end
    end
  end

  assign bus.rd_en_o     = rd_en;
  assign bus.rd_addr_a_o = base_a + idx;
  assign bus.rd_addr_b_o = base_b + idx;
  assign bus.wr_en_o     = wr_en;
  assign bus.wr_addr_o   = wr_addr;
  assign bus.wr_data_o   = wr_data;
  assign bus.busy_o      = busy;
  assign bus.done_o      = done;

endmodule

// File: tb/tb_poly_modsub_seq.sv
// tb/tb_poly_modsub_seq.sv - randomized self-checking bench for poly_modsub_seq
//
// Shared memory model serves both read ports and absorbs writes; expected results
// come from plain modular arithmetic on a snapshot taken before each run.
module tb_poly_modsub_seq;
  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int N     = 8;
  localparam int AMASK = (1 << AW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  poly_modsub_seq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  poly_modsub_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_COEFFS(N)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:AMASK];

  // read data valid exactly one cycle after rd_en_o, garbage otherwise
  always @(posedge clk) begin
    bus.rd_data_a_i <= bus.rd_en_o ? mem[bus.rd_addr_a_o] : DW'($urandom);
    bus.rd_data_b_i <= bus.rd_en_o ? mem[bus.rd_addr_b_o] : DW'($urandom);
    if (bus.wr_en_o) mem[bus.wr_addr_o] <= bus.wr_data_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".rd_en"},   32'(bus.rd_en_o),     32'd0);
    check({tag, ".rd_addr_a"}, 32'(bus.rd_addr_a_o), 32'd0);
    check({tag, ".rd_addr_b"}, 32'(bus.rd_addr_b_o), 32'd0);
    check({tag, ".wr_en"},   32'(bus.wr_en_o),     32'd0);
    check({tag, ".wr_addr"}, 32'(bus.wr_addr_o),   32'd0);
    check({tag, ".wr_data"}, 32'(bus.wr_data_o),   32'd0);
    check({tag, ".busy"},    32'(bus.busy_o),      32'd0);
    check({tag, ".done"},    32'(bus.done_o),      32'd0);
  endtask

  task automatic fill_rand(input int base, input int q);
    for (int k = 0; k < N; k++) mem[(base + k) & AMASK] = DW'($urandom_range(0, q - 1));
  endtask

  task automatic drive_cfg(input int q, input int ba, input int bb, input int bc, input bit op);
    bus.modulus_i = DW'(q);
    bus.base_a_i  = AW'(ba);
    bus.base_b_i  = AW'(bb);
    bus.base_c_i  = AW'(bc);
`ifdef POLY_MODSUB_ADD_EN
    bus.op_i      = op;
`else
    if (op) $display("note: add requested but feature not built");
`endif
  endtask

  // Called at a negedge; start is accepted at the following posedge (edge 0).
  task automatic run(input int q, input int ba, input int bb, input int bc,
                     input bit op, input bit repulse);
    int exp_d[N];
    for (int k = 0; k < N; k++) begin
      int a, b;
      a = int'(mem[(ba + k) & AMASK]);
      b = int'(mem[(bb + k) & AMASK]);
      exp_d[k] = op ? (a + b) % q : (((a - b) % q) + q) % q;
    end
    drive_cfg(q, ba, bb, bc, op);
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    // scramble config inputs: the design must use its latched copies
    drive_cfg(int'($urandom_range(1, 65535)), int'($urandom_range(0, AMASK)),
              int'($urandom_range(0, AMASK)), int'($urandom_range(0, AMASK)), 1'b0);
    for (int c = 1; c <= N + 4; c++) begin
      @(negedge clk);
      check($sformatf("rd_en@%0d", c), 32'(bus.rd_en_o), 32'(c <= N));
      if (c <= N) begin
        check($sformatf("rd_addr_a@%0d", c), 32'(bus.rd_addr_a_o), 32'((ba + c - 1) & AMASK));
        check($sformatf("rd_addr_b@%0d", c), 32'(bus.rd_addr_b_o), 32'((bb + c - 1) & AMASK));
      end
      check($sformatf("wr_en@%0d", c), 32'(bus.wr_en_o), 32'(c >= 3 && c <= N + 2));
      if (c >= 3 && c <= N + 2) begin
        check($sformatf("wr_addr@%0d", c), 32'(bus.wr_addr_o), 32'((bc + c - 3) & AMASK));
        check($sformatf("wr_data@%0d", c), 32'(bus.wr_data_o), 32'(exp_d[c - 3]));
      end
      check($sformatf("busy@%0d", c), 32'(bus.busy_o), 32'(c <= N + 2));
      check($sformatf("done@%0d", c), 32'(bus.done_o), 32'(c == N + 3));
      if (repulse) begin
        if (c == 2 || c == N + 3) bus.start_i = 1'b1;
        if (c == 3 || c == N + 4) bus.start_i = 1'b0;
      end
    end
  endtask

  function automatic bit pick_op();
`ifdef POLY_MODSUB_ADD_EN
    return bit'($urandom_range(0, 1));
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    int q, ba, bb, bc;
    bus.start_i = 1'b0;
    drive_cfg(0, 0, 0, 0, 1'b0);
    for (int i = 0; i <= AMASK; i++) mem[i] = '0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero("idle");

    // known vector, with start re-pulsed in cycle 2 and on the done cycle
    fill_rand('h10, 3329);
    fill_rand('h40, 3329);
    mem['h10] = 16'd5;    mem['h11] = 16'd0; mem['h12] = 16'd3328; mem['h13] = 16'd100;
    mem['h40] = 16'd10;   mem['h41] = 16'd0; mem['h42] = 16'd1;    mem['h43] = 16'd100;
    run(3329, 'h10, 'h40, 'h80, 1'b0, 1'b1);
    check("plan_c0", 32'(mem['h80]), 32'd3324);
    check("plan_c1", 32'(mem['h81]), 32'd0);
    check("plan_c2", 32'(mem['h82]), 32'd3327);
    check("plan_c3", 32'(mem['h83]), 32'd0);

    // wide intermediate at the largest 16-bit prime; start one cycle after done
    fill_rand('h18, 65521);
    fill_rand('h48, 65521);
    mem['h18] = 16'd65520; mem['h48] = 16'd0;
    mem['h19] = 16'd0;     mem['h49] = 16'd65520;
    run(65521, 'h18, 'h48, 'h90, 1'b0, 1'b0);
    check("wide_c0", 32'(mem['h90]), 32'd65520);
    check("wide_c1", 32'(mem['h91]), 32'd1);

    // address wrap on reads and writes
    fill_rand('hFE, 1000);
    fill_rand('h60, 1000);
    run(1000, 'hFE, 'h60, 'hFD, 1'b0, 1'b0);

    // in-place: destination overwrites source A
    fill_rand('h20, 7681);
    fill_rand('h50, 7681);
    run(7681, 'h20, 'h50, 'h20, 1'b0, 1'b0);

`ifdef POLY_MODSUB_ADD_EN
    fill_rand('h28, 3329);
    fill_rand('h58, 3329);
    mem['h28] = 16'd3000; mem['h58] = 16'd400;
    mem['h29] = 16'd1;    mem['h59] = 16'd2;
    run(3329, 'h28, 'h58, 'hA0, 1'b1, 1'b0);
    check("add_c0", 32'(mem['hA0]), 32'd71);
    check("add_c1", 32'(mem['hA1]), 32'd3);
`endif

    // randomized runs
    for (int i = 0; i < 8; i++) begin
      q  = int'($urandom_range(2, 65535));
      ba = int'($urandom_range(0, 'h37));
      bb = 'h40 + int'($urandom_range(0, 'h37));
      bc = (i % 3 == 0) ? ba : 'h80 + int'($urandom_range(0, 'h77));
      fill_rand(ba, q);
      fill_rand(bb, q);
      run(q, ba, bb, bc, pick_op(), bit'(i % 2));
    end

    // reset in the middle of a run
    fill_rand('h30, 3329);
    fill_rand('h70, 3329);
    drive_cfg(3329, 'h30, 'h70, 'hC0, 1'b0);
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("midrst");
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("rst_done@%0d", c), 32'(bus.done_o), 32'd0);
      check($sformatf("rst_wr@%0d", c), 32'(bus.wr_en_o), 32'd0);
      check($sformatf("rst_rd@%0d", c), 32'(bus.rd_en_o), 32'd0);
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("post_rst_busy@%0d", c), 32'(bus.busy_o), 32'd0);
      check($sformatf("post_rst_done@%0d", c), 32'(bus.done_o), 32'd0);
    end
    fill_rand('h30, 3329);
    fill_rand('h70, 3329);
    run(3329, 'h30, 'h70, 'hC0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
